// File: rtl/xalu_conf_pkg.sv
// Shared constants, field codes and FSM encoding for the ALU configuration bank.
package xalu_conf_pkg;

  localparam int N_ALU         = 4;
  localparam int N_W           = 5;
  localparam int ALU_FNS_W     = 4;
  localparam int DATA_W        = 32;
  localparam int ALU_CONF_BITS = 2*N_W + ALU_FNS_W;

  // Low two address bits select the field inside a slot.
  localparam logic [1:0] ALU_CONF_SELA = 2'd0;
  localparam logic [1:0] ALU_CONF_SELB = 2'd1;
  localparam logic [1:0] ALU_CONF_FNS  = 2'd2;
  localparam logic [1:0] ALU_CONF_WORD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/xalu_conf_slot.sv
// One ALU slot: shadow register written per field, active register loaded on commit.
// Shadow output port exists only when XALU_CONF_READBACK_EN is defined.
module xalu_conf_slot
  import xalu_conf_pkg::*;
#(
  parameter int SEL_W  = N_W,
  parameter int FNS_W  = ALU_FNS_W,
  parameter int CONF_W = 2*SEL_W + FNS_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        we_i,
  input  logic [CONF_W-1:0] wdata_i,
  input  logic              commit_i,
`ifdef XALU_CONF_READBACK_EN
  output logic [CONF_W-1:0] shadow_o,
`endif
  output logic [CONF_W-1:0] active_o
);

  logic [CONF_W-1:0] shadow_d, shadow_q;
  logic [CONF_W-1:0] active_d, active_q;

  always_comb begin
    shadow_d = shadow_q;
    if (we_i[ALU_CONF_SELA]) shadow_d[CONF_W-1 -: SEL_W] = wdata_i[SEL_W-1:0];
    if (we_i[ALU_CONF_SELB]) shadow_d[FNS_W +: SEL_W]    = wdata_i[SEL_W-1:0];
    if (we_i[ALU_CONF_FNS])  shadow_d[FNS_W-1:0]         = wdata_i[FNS_W-1:0];
    if (we_i[ALU_CONF_WORD]) shadow_d                    = wdata_i;
  end

  // Writes are blocked during the commit cycle, so shadow_q is already final here.
  always_comb begin
    active_d = active_q;
    if (commit_i) active_d = shadow_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

`ifdef XALU_CONF_READBACK_EN
  assign shadow_o = shadow_q;
`endif
  assign active_o = active_q;

endmodule

// File: rtl/xalu_conf.sv
// ALU configuration bank: control-bus writes to shadow, atomic shadow->active commit while engine idle.
// XALU_CONF_READBACK_EN enables shadow readback; otherwise reads pulse ctrl_rvalid with zero data.
module xalu_conf
  import xalu_conf_pkg::*;
#(
  parameter int N_ALU  = xalu_conf_pkg::N_ALU,
  parameter int N_W    = xalu_conf_pkg::N_W,
  parameter int FNS_W  = xalu_conf_pkg::ALU_FNS_W,
  parameter int DATA_W = xalu_conf_pkg::DATA_W,
  localparam int CONF_W = 2*N_W + FNS_W,
  localparam int ADDR_W = $clog2(N_ALU) + 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ctrl_valid,
  input  logic                    ctrl_we,
  input  logic [ADDR_W-1:0]       ctrl_addr,
  input  logic [DATA_W-1:0]       ctrl_data_in,
  output logic                    ctrl_ready,
  output logic                    ctrl_rvalid,
  output logic [DATA_W-1:0]       ctrl_data_out,
  input  logic                    update,
  input  logic                    engine_busy,
  output logic                    update_pending,
  output logic [N_ALU*CONF_W-1:0] configdata
);

  localparam int SLOT_W = ADDR_W - 2;

  state_e state_d, state_q;
  logic   ready_d, ready_q;
  logic   pending_d, pending_q;
  logic   rvalid_d, rvalid_q;

  logic              accept, wr_acc, rd_acc, commit;
  logic [SLOT_W-1:0] slot_idx;
  logic [1:0]        field;

  assign accept   = ctrl_valid && ready_q;
  assign wr_acc   = accept && ctrl_we;
  assign rd_acc   = accept && !ctrl_we;
  assign slot_idx = ctrl_addr[ADDR_W-1:2];
  assign field    = ctrl_addr[1:0];
  assign commit   = (state_q == ST_COMMIT);

`ifdef XALU_CONF_READBACK_EN
  logic [CONF_W-1:0] shadow [N_ALU];
`endif

  for (genvar i = 0; i < N_ALU; i++) begin : g_slot
    logic [3:0] we;
    assign we = (wr_acc && int'(slot_idx) == i) ? (4'b0001 << field) : 4'b0000;

    xalu_conf_slot #(
      .SEL_W (N_W),
      .FNS_W (FNS_W)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .we_i     (we),
      .wdata_i  (ctrl_data_in[CONF_W-1:0]),
      .commit_i (commit),
`ifdef XALU_CONF_READBACK_EN
      .shadow_o (shadow[i]),
`endif
      .active_o (configdata[i*CONF_W +: CONF_W])
    );
  end

  // WAIT absorbs repeated update pulses; COMMIT always lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (update) state_d = engine_busy ? ST_WAIT : ST_COMMIT;
      ST_WAIT:   if (!engine_busy) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    ready_d   = (state_d != ST_COMMIT);
    pending_d = (state_d != ST_IDLE);
    rvalid_d  = rd_acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b1;
      pending_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      pending_q <= pending_d;
      rvalid_q  <= rvalid_d;
    end
  end

`ifdef XALU_CONF_READBACK_EN
  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic [CONF_W-1:0] rd_word;

  always_comb begin
    rdata_d = rdata_q;
    rd_word = '0;
    if (rd_acc) begin
      rdata_d = '0;
      if (int'(slot_idx) < N_ALU) begin
        rd_word = shadow[slot_idx];
        case (field)
          ALU_CONF_SELA: rdata_d = DATA_W'(rd_word[CONF_W-1 -: N_W]);
          ALU_CONF_SELB: rdata_d = DATA_W'(rd_word[FNS_W +: N_W]);
          ALU_CONF_FNS:  rdata_d = DATA_W'(rd_word[FNS_W-1:0]);
          default:       rdata_d = DATA_W'(rd_word);
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign ctrl_data_out = rdata_q;
`else
  assign ctrl_data_out = '0;
`endif

  assign ctrl_ready     = ready_q;
  assign ctrl_rvalid    = rvalid_q;
  assign update_pending = pending_q;

endmodule

// File: tb/tb_xalu_conf.sv
// Bench for xalu_conf: read responses checked by a scoreboard queue, commit timing by directed checks.
module tb_xalu_conf;

`ifdef XALU_CONF_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ctrl_valid = 1'b0, ctrl_we = 1'b0;
  logic [3:0]  ctrl_addr = '0;
  logic [31:0] ctrl_data_in = '0;
  logic        ctrl_ready, ctrl_rvalid;
  logic [31:0] ctrl_data_out;
  logic        update = 1'b0, engine_busy = 1'b0, update_pending;
  logic [55:0] configdata;

  logic        d3_valid = 1'b0, d3_we = 1'b0;
  logic [3:0]  d3_addr = '0;
  logic [31:0] d3_din = '0;
  logic        d3_ready, d3_rvalid;
  logic [31:0] d3_dout;
  logic        d3_update = 1'b0, d3_busy = 1'b0, d3_pending;
  logic [41:0] d3_cfg;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q [$];
  logic [55:0] exp_cfg;

  always #5 clk = ~clk;

  xalu_conf u_dut (
    .clk(clk), .rst_n(rst_n), .ctrl_valid(ctrl_valid), .ctrl_we(ctrl_we),
    .ctrl_addr(ctrl_addr), .ctrl_data_in(ctrl_data_in), .ctrl_ready(ctrl_ready),
    .ctrl_rvalid(ctrl_rvalid), .ctrl_data_out(ctrl_data_out), .update(update),
    .engine_busy(engine_busy), .update_pending(update_pending), .configdata(configdata)
  );

  xalu_conf #(.N_ALU(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .ctrl_valid(d3_valid), .ctrl_we(d3_we),
    .ctrl_addr(d3_addr), .ctrl_data_in(d3_din), .ctrl_ready(d3_ready),
    .ctrl_rvalid(d3_rvalid), .ctrl_data_out(d3_dout), .update(d3_update),
    .engine_busy(d3_busy), .update_pending(d3_pending), .configdata(d3_cfg)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every read response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && ctrl_rvalid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", 64'(ctrl_data_out), 64'hDEAD);
      end else begin
        chk("read_data", 64'(ctrl_data_out), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!ctrl_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    ok = ctrl_ready;
    if (!ok) chk("ready_timeout", 64'(ctrl_ready), 64'd1);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bit ok;
    wait_ready(ok);
    if (ok) begin
      ctrl_valid = 1'b1; ctrl_we = 1'b1; ctrl_addr = a; ctrl_data_in = d;
      @(posedge clk); #1;
      ctrl_valid = 1'b0; ctrl_we = 1'b0;
    end
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    bit ok;
    wait_ready(ok);
    if (ok) begin
      ctrl_valid = 1'b1; ctrl_we = 1'b0; ctrl_addr = a;
      exp_q.push_back(RB ? e : 32'd0);
      @(posedge clk); #1;
      ctrl_valid = 1'b0;
    end
  endtask

  task automatic upd();
    update = 1'b1;
    @(posedge clk); #1;
    update = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_cfg = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_configdata", 64'(configdata), 64'd0);
    chk("rst_pending", 64'(update_pending), 64'd0);
    chk("rst_rvalid", 64'(ctrl_rvalid), 64'd0);
    chk("rst_dout", 64'(ctrl_data_out), 64'd0);
    chk("rst_ready", 64'(ctrl_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Field writes to slot 0, then commit from IDLE
    wr(4'h0, 32'd3);
    wr(4'h1, 32'd7);
    wr(4'h2, 32'd2);
    chk("shadow_only", 64'(configdata), 64'd0);
    upd();
    chk("commit_cycle_cfg_old", 64'(configdata), 64'd0);
    chk("commit_cycle_ready", 64'(ctrl_ready), 64'd0);
    chk("commit_cycle_pending", 64'(update_pending), 64'd1);
    @(posedge clk); #1;
    exp_cfg[13:0] = 14'h0672;
    chk("commit_slot0", 64'(configdata), 64'(exp_cfg));
    chk("commit_done_pending", 64'(update_pending), 64'd0);
    chk("commit_done_ready", 64'(ctrl_ready), 64'd1);

    // Busy engine: whole-word write with excess bits, repeated update pulses
    engine_busy = 1'b1;
    wr(4'hB, 32'hFFFF_DABC);
    upd();
    @(posedge clk); #1;
    upd();
    upd();
    @(posedge clk); #1;
    chk("wait_pending", 64'(update_pending), 64'd1);
    chk("wait_ready", 64'(ctrl_ready), 64'd1);
    chk("wait_cfg_held", 64'(configdata), 64'(exp_cfg));
    engine_busy = 1'b0;
    @(posedge clk); #1;
    chk("wait_to_commit_ready", 64'(ctrl_ready), 64'd0);
    chk("wait_to_commit_cfg", 64'(configdata), 64'(exp_cfg));
    @(posedge clk); #1;
    exp_cfg[28 +: 14] = 14'h1ABC;
    chk("wait_commit_slot2", 64'(configdata), 64'(exp_cfg));
    chk("wait_commit_pending", 64'(update_pending), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("single_commit_ready", 64'(ctrl_ready), 64'd1);
    chk("single_commit_pending", 64'(update_pending), 64'd0);

    // Write and update in the same IDLE cycle
    ctrl_valid = 1'b1; ctrl_we = 1'b1; ctrl_addr = 4'h7; ctrl_data_in = 32'h0000_2AAF;
    update = 1'b1;
    @(posedge clk); #1;
    ctrl_valid = 1'b0; ctrl_we = 1'b0; update = 1'b0;
    @(posedge clk); #1;
    exp_cfg[14 +: 14] = 14'h2AAF;
    chk("same_cycle_slot1", 64'(configdata), 64'(exp_cfg));

    // Partial field overwrite and readback of shadow contents
    wr(4'hE, 32'd9);
    wr(4'h1, 32'hFFFF_FFE1);
    chk("partial_write_no_commit", 64'(configdata), 64'(exp_cfg));
    rd(4'hE, 32'd9);
    rd(4'hF, 32'd9);
    rd(4'h0, 32'd3);
    rd(4'h1, 32'd1);
    rd(4'h3, 32'h0000_0612);
    rd(4'h9, 32'd11);
    rd(4'hA, 32'd12);
    rd(4'h7, 32'h0000_2AAF);
    @(posedge clk); #1;
    chk("rvalid_one_cycle", 64'(ctrl_rvalid), 64'd0);

    // Out-of-range slot on a 3-slot instance
    chk("oor_ready", 64'(d3_ready), 64'd1);
    d3_valid = 1'b1; d3_we = 1'b1; d3_addr = 4'hF; d3_din = 32'h0000_3FFF;
    @(posedge clk); #1;
    d3_valid = 1'b0; d3_we = 1'b0; d3_update = 1'b1;
    @(posedge clk); #1;
    d3_update = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("oor_cfg_unchanged", 64'(d3_cfg), 64'd0);
    chk("oor_pending", 64'(d3_pending), 64'd0);
    d3_valid = 1'b1; d3_we = 1'b0; d3_addr = 4'hE;
    @(posedge clk); #1;
    d3_valid = 1'b0;
    chk("oor_rvalid", 64'(d3_rvalid), 64'd1);
    chk("oor_rdata", 64'(d3_dout), 64'd0);
    @(posedge clk); #1;
    chk("oor_rvalid_drop", 64'(d3_rvalid), 64'd0);

    // Reset in the middle of WAIT
    engine_busy = 1'b1;
    wr(4'hF, 32'h0000_1234);
    upd();
    chk("pre_reset_pending", 64'(update_pending), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_cfg", 64'(configdata), 64'd0);
    chk("async_rst_pending", 64'(update_pending), 64'd0);
    chk("async_rst_ready", 64'(ctrl_ready), 64'd1);
    engine_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_no_commit_cfg", 64'(configdata), 64'd0);
    chk("post_rst_no_commit_pending", 64'(update_pending), 64'd0);
    rd(4'hF, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
